// File: rtl/dma_burst_arbiter_pkg.sv
// Shared types and default sizing for the DMA burst arbiter.
// The two write masters run the same IDLE/BUSY state machine.
package dma_burst_arbiter_pkg;

  localparam int DEF_NUM_REQ            = 4;
  localparam int DEF_ADDR_WIDTH         = 32;
  localparam int DEF_FIFO_COUNTER_WIDTH = 8;
  localparam int DEF_IDX_W              = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mst_state_e;

endpackage

// File: rtl/dma_burst_arbiter_rr_pick.sv
// Round-robin selector: first eligible requester at or after ptr, wrapping.
module rr_pick
  import dma_burst_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = DEF_IDX_W
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   index
);

  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!valid && eligible[(int'(ptr) + k) % NUM_REQ]) begin
        valid = 1'b1;
        index = IDX_W'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/dma_burst_arbiter.sv
// Hands burst requests from NUM_REQ requesters to two AXI write masters,
// throttled by HP FIFO fill levels, and routes completions back to owners.
module dma_burst_arbiter
  import dma_burst_arbiter_pkg::*;
#(
  parameter int NUM_REQ            = DEF_NUM_REQ,
  parameter int ADDR_WIDTH         = DEF_ADDR_WIDTH,
  parameter int FIFO_Counter_WIDTH = DEF_FIFO_COUNTER_WIDTH,
  parameter int IDX_W              = DEF_IDX_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [FIFO_Counter_WIDTH-1:0] HP0_FIFO_Counter,
  input  logic [FIFO_Counter_WIDTH-1:0] HP1_FIFO_Counter,
  input  logic [FIFO_Counter_WIDTH-1:0] WARNING_THRES,
  input  logic                          INIT_AXI_TXN_DONE_1,
  input  logic                          INIT_AXI_TXN_DONE_2,
  output logic                          INIT_AXI_TXN_1,
  output logic                          INIT_AXI_TXN_2,
  output logic [ADDR_WIDTH-1:0]         BIAS_ADDR_1,
  output logic [ADDR_WIDTH-1:0]         BIAS_ADDR_2,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            done,
  output logic [IDX_W-1:0]              owner_1,
  output logic [IDX_W-1:0]              owner_2,
  output logic                          busy_1,
  output logic                          busy_2,
  output logic                          spurious_done
);

  mst_state_e state_1, state_1_nxt;
  mst_state_e state_2, state_2_nxt;

  logic [IDX_W-1:0]      ptr, ptr_nxt;
  logic [NUM_REQ-1:0]    req_elig;
  logic                  pick_valid;
  logic [IDX_W-1:0]      pick_idx;
  logic [ADDR_WIDTH-1:0] pick_addr;
  logic                  m1_ok, m2_ok;
  logic                  fire_1, fire_2;
  logic                  fin_1, fin_2;
  logic                  stray;
  logic [NUM_REQ-1:0]    grant_nxt, done_nxt;

  assign busy_1 = (state_1 == BUSY);
  assign busy_2 = (state_2 == BUSY);

  assign m1_ok = (state_1 == IDLE) && (HP0_FIFO_Counter < WARNING_THRES);
  assign m2_ok = (state_2 == IDLE) && (HP1_FIFO_Counter < WARNING_THRES);

  // A requester already holding a busy master waits until that burst ends.
  always_comb begin
    req_elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_elig[i] = req[i]
                  && !(busy_1 && (owner_1 == IDX_W'(i)))
                  && !(busy_2 && (owner_2 == IDX_W'(i)));
    end
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .eligible (req_elig),
    .ptr      (ptr),
    .valid    (pick_valid),
    .index    (pick_idx)
  );

  assign pick_addr = req_addr[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];

  assign fire_1 = pick_valid && m1_ok;
  assign fire_2 = pick_valid && !m1_ok && m2_ok;
  assign fin_1  = INIT_AXI_TXN_DONE_1 && busy_1;
  assign fin_2  = INIT_AXI_TXN_DONE_2 && busy_2;
  assign stray  = (INIT_AXI_TXN_DONE_1 && !busy_1) || (INIT_AXI_TXN_DONE_2 && !busy_2);

  always_comb begin
    state_1_nxt = state_1;
    state_2_nxt = state_2;
    ptr_nxt     = ptr;
    grant_nxt   = '0;
    done_nxt    = '0;

    if (fin_1)       state_1_nxt = IDLE;
    else if (fire_1) state_1_nxt = BUSY;

    if (fin_2)       state_2_nxt = IDLE;
    else if (fire_2) state_2_nxt = BUSY;

    if (fire_1 || fire_2) begin
      grant_nxt[pick_idx] = 1'b1;
      ptr_nxt = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
    end

    if (fin_1) done_nxt[owner_1] = 1'b1;
    if (fin_2) done_nxt[owner_2] = 1'b1;
  end

  // Address and owner are only loaded on a grant so they stay readable after completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_1        <= IDLE;
      state_2        <= IDLE;
      ptr            <= '0;
      grant          <= '0;
      done           <= '0;
      INIT_AXI_TXN_1 <= 1'b0;
      INIT_AXI_TXN_2 <= 1'b0;
      BIAS_ADDR_1    <= '0;
      BIAS_ADDR_2    <= '0;
      owner_1        <= '0;
      owner_2        <= '0;
      spurious_done  <= 1'b0;
    end else begin
      state_1        <= state_1_nxt;
      state_2        <= state_2_nxt;
      ptr            <= ptr_nxt;
      grant          <= grant_nxt;
      done           <= done_nxt;
      INIT_AXI_TXN_1 <= fire_1;
      INIT_AXI_TXN_2 <= fire_2;
      if (fire_1) begin
        BIAS_ADDR_1 <= pick_addr;
        owner_1     <= pick_idx;
      end
      if (fire_2) begin
        BIAS_ADDR_2 <= pick_addr;
        owner_2     <= pick_idx;
      end
      if (stray) spurious_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dma_burst_arbiter.sv
// Self-checking bench for dma_burst_arbiter: vector table plus multi-cycle
// sequences, with grants checked against a queue of expected records.
module tb_dma_burst_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [127:0] req_addr;
  logic [7:0]  hp0, hp1, thres;
  logic        done_in_1, done_in_2;
  logic        init_1, init_2;
  logic [31:0] bias_1, bias_2;
  logic [3:0]  grant, done;
  logic [1:0]  owner_1, owner_2;
  logic        busy_1, busy_2;
  logic        spurious_done;

  dma_burst_arbiter dut (
    .clk                 (clk),
    .rst                 (rst),
    .req                 (req),
    .req_addr            (req_addr),
    .HP0_FIFO_Counter    (hp0),
    .HP1_FIFO_Counter    (hp1),
    .WARNING_THRES       (thres),
    .INIT_AXI_TXN_DONE_1 (done_in_1),
    .INIT_AXI_TXN_DONE_2 (done_in_2),
    .INIT_AXI_TXN_1      (init_1),
    .INIT_AXI_TXN_2      (init_2),
    .BIAS_ADDR_1         (bias_1),
    .BIAS_ADDR_2         (bias_2),
    .grant               (grant),
    .done                (done),
    .owner_1             (owner_1),
    .owner_2             (owner_2),
    .busy_1              (busy_1),
    .busy_2              (busy_2),
    .spurious_done       (spurious_done)
  );

  typedef struct {
    logic [3:0] req;
    logic [7:0] hp0;
    logic [7:0] hp1;
    logic [7:0] thres;
    logic [3:0] exp_grant;
    int         exp_m;
    logic [1:0] exp_owner;
  } vec_t;

  typedef struct {
    logic [3:0]  grant;
    int          m;
    logic [1:0]  owner;
    logic [31:0] bias;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[8];
  logic [31:0] addr_tab[4];
  int          checks = 0;
  int          errors = 0;

  exp_t        mon_e;
  logic [31:0] mon_bias;
  logic [1:0]  mon_owner;
  int          cnt1, cnt2, seen, cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pushExp(input logic [3:0] g, input int m, input logic [1:0] o);
    exp_t e;
    e.grant = g;
    e.m     = m;
    e.owner = o;
    e.bias  = addr_tab[o];
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input vec_t v);
    req   = v.req;
    hp0   = v.hp0;
    hp1   = v.hp1;
    thres = v.thres;
    if (v.exp_m != 0) pushExp(v.exp_grant, v.exp_m, v.exp_owner);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: every grant pulse must match the oldest pending record.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (grant !== 4'b0 || init_1 || init_2) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL sb_unexpected: grant=%b init1=%b init2=%b, expected no grant", grant, init_1, init_2);
        end else begin
          mon_e     = sb.pop_front();
          mon_bias  = (mon_e.m == 1) ? bias_1 : bias_2;
          mon_owner = (mon_e.m == 1) ? owner_1 : owner_2;
          if (grant !== mon_e.grant || init_1 !== (mon_e.m == 1) || init_2 !== (mon_e.m == 2)
              || mon_bias !== mon_e.bias || mon_owner !== mon_e.owner) begin
            errors++;
            $display("[TB] FAIL sb_grant: got grant=%b init1=%b init2=%b bias=0x%0h owner=%0d, expected grant=%b master=%0d bias=0x%0h owner=%0d",
                     grant, init_1, init_2, mon_bias, mon_owner, mon_e.grant, mon_e.m, mon_e.bias, mon_e.owner);
          end
        end
      end
    end
  end

  initial begin
    addr_tab[0] = 32'hA000_0000;
    addr_tab[1] = 32'hB000_0010;
    addr_tab[2] = 32'h0000_1000;
    addr_tab[3] = 32'hC000_0FF0;
    req_addr = {addr_tab[3], addr_tab[2], addr_tab[1], addr_tab[0]};

    vecs[0] = '{4'b0100, 8'd0,   8'd0,   8'd128, 4'b0100, 1, 2'd2};
    vecs[1] = '{4'b0001, 8'd200, 8'd0,   8'd128, 4'b0001, 2, 2'd0};
    vecs[2] = '{4'b0001, 8'd200, 8'd200, 8'd128, 4'b0000, 0, 2'd0};
    vecs[3] = '{4'b1000, 8'd100, 8'd200, 8'd128, 4'b1000, 1, 2'd3};
    vecs[4] = '{4'b0000, 8'd0,   8'd0,   8'd128, 4'b0000, 0, 2'd0};
    vecs[5] = '{4'b0010, 8'd128, 8'd127, 8'd128, 4'b0010, 2, 2'd1};
    vecs[6] = '{4'b0010, 8'd127, 8'd128, 8'd128, 4'b0010, 1, 2'd1};
    vecs[7] = '{4'b0100, 8'd0,   8'd0,   8'd0,   4'b0000, 0, 2'd0};

    rst = 1'b1; req = '0; hp0 = '0; hp1 = '0; thres = 8'd128;
    done_in_1 = 1'b0; done_in_2 = 1'b0;
    repeat (2) tick();
    checkOutput("reset pulses", {grant, done, init_1, init_2}, 32'h0);
    checkOutput("reset bias_1", bias_1, 32'h0);
    checkOutput("reset bias_2", bias_2, 32'h0);
    checkOutput("reset status", {owner_1, owner_2, busy_1, busy_2, spurious_done}, 32'h0);
    rst = 1'b0;
    tick();

    // Single-request vectors, each burst completed before the next one.
    for (int v = 0; v < 8; v++) begin
      applyStimulus(vecs[v]);
      tick();
      checkOutput($sformatf("vec%0d grant", v), grant, vecs[v].exp_grant);
      checkOutput($sformatf("vec%0d busy", v), {busy_2, busy_1},
                  {vecs[v].exp_m == 2, vecs[v].exp_m == 1});
      req = '0;
      if (vecs[v].exp_m != 0) begin
        done_in_1 = (vecs[v].exp_m == 1);
        done_in_2 = (vecs[v].exp_m == 2);
        tick();
        done_in_1 = 1'b0;
        done_in_2 = 1'b0;
        checkOutput($sformatf("vec%0d done", v), done, vecs[v].exp_grant);
        checkOutput($sformatf("vec%0d idle", v), {busy_2, busy_1}, 32'h0);
        checkOutput($sformatf("vec%0d owner hold", v),
                    (vecs[v].exp_m == 1) ? owner_1 : owner_2, vecs[v].exp_owner);
      end
    end

    // Round robin with all requests held and a 5-cycle burst responder.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b1111; hp0 = '0; hp1 = '0; thres = 8'd128;
    pushExp(4'b0001, 1, 2'd0);
    pushExp(4'b0010, 2, 2'd1);
    pushExp(4'b0100, 1, 2'd2);
    pushExp(4'b1000, 2, 2'd3);
    pushExp(4'b0001, 1, 2'd0);
    cnt1 = 0; cnt2 = 0; seen = 0; cyc = 0;
    while (cyc < 80) begin
      tick();
      cyc++;
      done_in_1 = 1'b0;
      done_in_2 = 1'b0;
      if (grant != 4'b0) seen++;
      if (seen >= 5) req = '0;
      if (cnt1 > 0) begin cnt1--; if (cnt1 == 0) done_in_1 = 1'b1; end
      if (cnt2 > 0) begin cnt2--; if (cnt2 == 0) done_in_2 = 1'b1; end
      if (init_1) cnt1 = 5;
      if (init_2) cnt2 = 5;
      if (seen >= 5 && cnt1 == 0 && cnt2 == 0 && !done_in_1 && !done_in_2 && !busy_1 && !busy_2) break;
    end
    checkOutput("rr grant count", seen, 5);
    checkOutput("rr drained in budget", (cyc < 80), 1);

    // Throttling: master 1 blocked, then both blocked, then master 1 released.
    hp0 = 8'd200; hp1 = 8'd0; thres = 8'd128; req = 4'b0001;
    pushExp(4'b0001, 2, 2'd0);
    tick();
    checkOutput("thr init pair", {init_1, init_2}, 32'b01);
    req = '0;
    done_in_2 = 1'b1;
    tick();
    done_in_2 = 1'b0;
    checkOutput("thr done m2", done, 4'b0001);
    hp1 = 8'd200; req = 4'b0001;
    for (int c = 0; c < 4; c++) begin
      tick();
      checkOutput($sformatf("thr blocked c%0d", c), grant, 4'b0000);
    end
    hp0 = 8'd100;
    pushExp(4'b0001, 1, 2'd0);
    tick();
    req = '0;
    checkOutput("thr release busy_1", busy_1, 1'b1);
    hp0 = 8'd200; hp1 = 8'd200; done_in_1 = 1'b1;
    tick();
    done_in_1 = 1'b0;
    checkOutput("thr busy completes", done, 4'b0001);
    checkOutput("thr busy_1 cleared", busy_1, 1'b0);

    // Simultaneous completion on both masters.
    hp0 = '0; hp1 = '0; req = 4'b0011;
    pushExp(4'b0010, 1, 2'd1);
    pushExp(4'b0001, 2, 2'd0);
    tick();
    tick();
    req = '0;
    checkOutput("both busy", {busy_2, busy_1}, 32'b11);
    done_in_1 = 1'b1; done_in_2 = 1'b1; req = 4'b0100;
    pushExp(4'b0100, 1, 2'd2);
    tick();
    done_in_1 = 1'b0; done_in_2 = 1'b0;
    checkOutput("dual done", done, 4'b0011);
    checkOutput("dual no grant yet", grant, 4'b0000);
    checkOutput("dual idle", {busy_2, busy_1}, 32'b00);
    tick();
    req = '0;
    checkOutput("regrant after done", grant, 4'b0100);
    done_in_1 = 1'b1;
    tick();
    done_in_1 = 1'b0;
    checkOutput("regrant done", done, 4'b0100);

    // Stray completion on an idle master, then reset in the middle of a burst.
    done_in_2 = 1'b1;
    tick();
    done_in_2 = 1'b0;
    checkOutput("spurious set", spurious_done, 1'b1);
    checkOutput("spurious no done", done, 4'b0000);
    tick();
    checkOutput("spurious sticky", spurious_done, 1'b1);
    req = 4'b0001;
    pushExp(4'b0001, 1, 2'd0);
    tick();
    req = '0;
    checkOutput("pre-reset busy_1", busy_1, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async reset pulses", {grant, done, init_1, init_2}, 32'h0);
    checkOutput("async reset status", {owner_1, owner_2, busy_1, busy_2, spurious_done}, 32'h0);
    checkOutput("async reset bias_1", bias_1, 32'h0);
    tick();
    rst = 1'b0;
    done_in_1 = 1'b1;
    tick();
    done_in_1 = 1'b0;
    checkOutput("orphan done spurious", spurious_done, 1'b1);
    checkOutput("orphan done no pulse", done, 4'b0000);

    tick();
    checkOutput("sb drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dma_burst_arbiter.md
DMA_BURST_ARBITER -- requirements
Module: dma_burst_arbiter

Interface
REQ-001 Parameters (name, default, meaning): NUM_REQ, 4, requester count; ADDR_WIDTH, 32, address width; FIFO_Counter_WIDTH, 8, HP FIFO counter width; IDX_W, 2, requester index width (clog2 of NUM_REQ).
REQ-002 clk  in  1  sole clock; all state changes on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 req  in  NUM_REQ  level burst request per requester.
REQ-005 req_addr  in  NUM_REQ*ADDR_WIDTH  burst bias address per requester; slice i belongs to requester i.
REQ-006 HP0_FIFO_Counter, HP1_FIFO_Counter  in  FIFO_Counter_WIDTH each  HP port FIFO fill levels.
REQ-007 WARNING_THRES  in  FIFO_Counter_WIDTH  throttle threshold.
REQ-008 INIT_AXI_TXN_DONE_1, INIT_AXI_TXN_DONE_2  in  1 each  burst-complete pulses from write masters 1 and 2.
REQ-009 INIT_AXI_TXN_1, INIT_AXI_TXN_2  out  1 each  one-cycle burst start pulses.
REQ-010 BIAS_ADDR_1, BIAS_ADDR_2  out  ADDR_WIDTH each  registered burst address per master.
REQ-011 grant  out  NUM_REQ  one-hot, one-cycle grant pulse.
REQ-012 done  out  NUM_REQ  one-cycle completion pulse routed to owning requester.
REQ-013 owner_1, owner_2  out  IDX_W each  requester index owning each master.
REQ-014 busy_1, busy_2  out  1 each  master has outstanding burst.
REQ-015 spurious_done  out  1  sticky error flag.

Function
REQ-016 Each master has FSM IDLE -> BUSY (on grant to that master) -> IDLE (on its DONE); busy_x SHALL equal (state==BUSY).
REQ-017 Master 1 SHALL be eligible when IDLE and HP0_FIFO_Counter < WARNING_THRES; master 2 likewise with HP1_FIFO_Counter.
REQ-018 Requester i SHALL be eligible when req[i]=1 and it owns no BUSY master.
REQ-019 At most one grant per cycle; target master = master 1 if eligible, else master 2.
REQ-020 Requester selection SHALL be round-robin: first eligible index at or after pointer ptr, wrapping modulo NUM_REQ; ptr SHALL become granted index+1 (mod NUM_REQ) on grant, unchanged otherwise.
REQ-021 Decision on edge N SHALL produce, in cycle N+1 (registered): grant[i]=1, INIT_AXI_TXN_x=1, BIAS_ADDR_x=req_addr slice i, owner_x=i, busy_x=1.
REQ-022 Requester SHALL deassert req or present next address in the cycle grant is seen; a req still high is re-evaluated only after its burst completes (REQ-018).
REQ-023 INIT_AXI_TXN_DONE_x while BUSY SHALL produce done[owner_x]=1 next cycle and IDLE next cycle; that master is eligible for decision on the following edge (earliest new INIT two cycles after DONE).
REQ-024 Both DONE pulses same cycle SHALL both complete; both done bits pulse together.
REQ-025 DONE on an IDLE master SHALL be ignored except spurious_done set to 1 and held until reset.
REQ-026 Throttle (counter >= WARNING_THRES) SHALL only block new grants; BUSY bursts continue and complete normally.
REQ-027 BIAS_ADDR_x and owner_x SHALL hold their values after completion until next grant to that master.
REQ-028 No requests or no eligible master: all pulse outputs 0, state and ptr unchanged.

Reset
REQ-029 rst=1 SHALL immediately force: both FSMs IDLE, ptr=0, all pulse outputs 0, BIAS_ADDR_x=0, owner_x=0, busy_x=0, spurious_done=0.
REQ-030 Reset mid-burst SHALL drop ownership silently; a later DONE for that burst sets spurious_done.

Structure
REQ-031 Shared package SHALL hold FSM state encoding (IDLE=1'b0, BUSY=1'b1) and default parameter constants.
REQ-032 One sub-module, rr_pick, SHALL implement round-robin selection (inputs eligible vector, ptr; outputs valid, index); instantiated once.

Verification
REQ-033 Single req[2], addr 0x1000, counters 0 -> grant[2] and INIT_AXI_TXN_1 next cycle, BIAS_ADDR_1=0x1000, owner_1=2.
REQ-034 req=4'b1111 held, DONE each burst 5 cycles later -> grants in order 0,1,2,3,0 alternating masters 1,2 when both free.
REQ-035 HP0_FIFO_Counter=200, WARNING_THRES=128, req[0] -> INIT_AXI_TXN_2 only; set HP1_FIFO_Counter=200 too -> no grant until a counter drops to 100.
REQ-036 Both masters BUSY, DONE_1 and DONE_2 same cycle -> both done bits pulse next cycle; new grant two cycles after DONE.
REQ-037 INIT_AXI_TXN_DONE_2 with master 2 IDLE -> spurious_done=1, no done pulse; rst mid-burst -> all outputs 0 same cycle.
